hv_owt_rac_ctrl: RTL and testbench

Register-access controller behind the HV one-wire receiver. It consumes each decoded frame (cmd/data/status) and sequences a register-file write or read. After a fixed bus-turnaround delay it issues the matching response request to the one-wire transmitter. Write, normal-read and ADC-burst-read (read of address 0x1F) transactions are serialized. Errored and overlapping frames are dropped and flagged.

---
 rtl/hv_owt_rac_pkg.sv | 21 ++
 rtl/hv_owt_rac_ctrl.sv | 133 +++++++++++++
 tb/tb_hv_owt_rac_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hv_owt_rac_pkg.sv
// hv_owt_rac_pkg: shared types and constants for the HV one-wire register-access controller
//   rac_state_e  : controller FSM states
//   ADC_RD_ADDR  : read address that selects an ADC response frame
//   CMD_*        : field positions inside the received command byte
package hv_owt_rac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REG_WR = 3'd1,
        ST_REG_RD = 3'd2,
        ST_TURN   = 3'd3,
        ST_TX     = 3'd4
    } rac_state_e;

    localparam int          ADDR_W       = 7;
    localparam logic [6:0]  ADC_RD_ADDR  = 7'h1F;
    localparam int          CMD_WR_BIT   = 7;
    localparam int          CMD_ADDR_MSB = 6;
    localparam int          CMD_ADDR_LSB = 0;

endpackage

// File: rtl/hv_owt_rac_ctrl.sv
// hv_owt_rac_ctrl: sequences a register write/read per received one-wire frame, then requests the response
//   i_clk / i_rst_n          : clock, asynchronous active-low reset
//   i_owt_rx_rac_*           : decoded rx frame (vld pulse, cmd, data, status)
//   o_rac_reg_* / i_reg_rac_*: register-file access strobes, address, data and ack
//   o_rac_owt_tx_* / i_owt_tx_rac_done : response request to the one-wire transmitter
//   o_rac_busy / o_rac_overrun / o_rac_reg_to : status and event pulses
module hv_owt_rac_ctrl
    import hv_owt_rac_pkg::*;
#(
    parameter int OWT_CMD_BIT_NUM  = 8,
    parameter int OWT_DATA_BIT_NUM = 8,
    parameter int TURN_CYC         = 16,
    parameter int ACK_TO_CYC       = 8,
    parameter int CNT_W            = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_owt_rx_rac_vld,
    input  logic [OWT_CMD_BIT_NUM-1:0]  i_owt_rx_rac_cmd,
    input  logic [OWT_DATA_BIT_NUM-1:0] i_owt_rx_rac_data,
    input  logic                        i_owt_rx_rac_status,
    output logic                        o_rac_reg_wr_en,
    output logic                        o_rac_reg_rd_en,
    output logic [ADDR_W-1:0]           o_rac_reg_addr,
    output logic [OWT_DATA_BIT_NUM-1:0] o_rac_reg_wdata,
    input  logic                        i_reg_rac_ack,
    input  logic [OWT_DATA_BIT_NUM-1:0] i_reg_rac_rdata,
    output logic                        o_rac_owt_tx_req,
    output logic [OWT_CMD_BIT_NUM-1:0]  o_rac_owt_tx_cmd,
    output logic [OWT_DATA_BIT_NUM-1:0] o_rac_owt_tx_data,
    output logic                        o_rac_owt_tx_adc_sel,
    input  logic                        i_owt_tx_rac_done,
    output logic                        o_rac_busy,
    output logic                        o_rac_overrun,
    output logic                        o_rac_reg_to
);

    rac_state_e                  r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [OWT_CMD_BIT_NUM-1:0]  r_cmd;
    logic [OWT_DATA_BIT_NUM-1:0] r_data;
    logic [OWT_DATA_BIT_NUM-1:0] r_tx_data;
    logic                        r_adc_sel;
    logic                        r_overrun;
    logic                        r_reg_to;

    logic w_ack_last;
    logic w_turn_last;
    logic w_is_adc;

    assign w_ack_last  = r_cnt == CNT_W'(ACK_TO_CYC - 1);
    assign w_turn_last = r_cnt == CNT_W'(TURN_CYC - 1);
    assign w_is_adc    = i_owt_rx_rac_cmd[CMD_ADDR_MSB:CMD_ADDR_LSB] == ADC_RD_ADDR;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cmd     <= '0;
            r_data    <= '0;
            r_tx_data <= '0;
            r_adc_sel <= 1'b0;
            r_overrun <= 1'b0;
            r_reg_to  <= 1'b0;
        end else begin
            // any frame arriving outside IDLE is dropped, including one coincident with done
            r_overrun <= i_owt_rx_rac_vld && (r_state != ST_IDLE);
            r_reg_to  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_owt_rx_rac_vld && !i_owt_rx_rac_status) begin
                        r_cmd  <= i_owt_rx_rac_cmd;
                        r_data <= i_owt_rx_rac_data;
                        r_cnt  <= '0;
                        if (i_owt_rx_rac_cmd[CMD_WR_BIT]) begin
                            r_state <= ST_REG_WR;
                        end else if (w_is_adc) begin
                            // ADC reads skip the register file; the transmitter supplies the payload
                            r_state   <= ST_TURN;
                            r_adc_sel <= 1'b1;
                            r_tx_data <= '0;
                        end else begin
                            r_state <= ST_REG_RD;
                        end
                    end
                end
                ST_REG_WR, ST_REG_RD: begin
                    // ack in the final cycle still completes the access
                    if (i_reg_rac_ack) begin
                        r_state   <= ST_TURN;
                        r_cnt     <= '0;
                        r_tx_data <= (r_state == ST_REG_RD) ? i_reg_rac_rdata : r_data;
                    end else if (w_ack_last) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_adc_sel <= 1'b0;
                        r_reg_to  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_TURN: begin
                    r_state <= w_turn_last ? ST_TX : ST_TURN;
                    r_cnt   <= w_turn_last ? '0 : r_cnt + 1'b1;
                end
                ST_TX: begin
                    if (i_owt_tx_rac_done) begin
                        r_state   <= ST_IDLE;
                        r_adc_sel <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_adc_sel <= 1'b0;
                end
            endcase
        end
    end

    assign o_rac_reg_wr_en      = r_state == ST_REG_WR;
    assign o_rac_reg_rd_en      = r_state == ST_REG_RD;
    assign o_rac_reg_addr       = r_cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
    assign o_rac_reg_wdata      = r_data;
    assign o_rac_owt_tx_req     = r_state == ST_TX;
    assign o_rac_owt_tx_cmd     = r_cmd;
    assign o_rac_owt_tx_data    = r_tx_data;
    assign o_rac_owt_tx_adc_sel = r_adc_sel;
    assign o_rac_busy           = r_state != ST_IDLE;
    assign o_rac_overrun        = r_overrun;
    assign o_rac_reg_to         = r_reg_to;

endmodule

// File: tb/tb_hv_owt_rac_ctrl.sv
// tb_hv_owt_rac_ctrl: directed bench with a response scoreboard for hv_owt_rac_ctrl
module tb_hv_owt_rac_ctrl;

    localparam int TURN_CYC   = 16;
    localparam int ACK_TO_CYC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld = 1'b0;
    logic [7:0] rx_cmd = '0;
    logic [7:0] rx_data = '0;
    logic       rx_status = 1'b0;
    logic       wr_en, rd_en;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       ack = 1'b0;
    logic [7:0] rdata = '0;
    logic       tx_req;
    logic [7:0] tx_cmd, tx_data;
    logic       adc_sel;
    logic       done = 1'b0;
    logic       busy, overrun, reg_to;

    hv_owt_rac_ctrl #(
        .OWT_CMD_BIT_NUM(8), .OWT_DATA_BIT_NUM(8),
        .TURN_CYC(TURN_CYC), .ACK_TO_CYC(ACK_TO_CYC), .CNT_W(5)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_owt_rx_rac_vld(vld), .i_owt_rx_rac_cmd(rx_cmd),
        .i_owt_rx_rac_data(rx_data), .i_owt_rx_rac_status(rx_status),
        .o_rac_reg_wr_en(wr_en), .o_rac_reg_rd_en(rd_en),
        .o_rac_reg_addr(addr), .o_rac_reg_wdata(wdata),
        .i_reg_rac_ack(ack), .i_reg_rac_rdata(rdata),
        .o_rac_owt_tx_req(tx_req), .o_rac_owt_tx_cmd(tx_cmd),
        .o_rac_owt_tx_data(tx_data), .o_rac_owt_tx_adc_sel(adc_sel),
        .i_owt_tx_rac_done(done),
        .o_rac_busy(busy), .o_rac_overrun(overrun), .o_rac_reg_to(reg_to)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_wr = 0, n_rd = 0, n_to = 0, n_ovr = 0, n_tx = 0;
    int rise_cyc = 0;
    logic        prev_req = 1'b0;
    logic [16:0] cur = '0;
    logic [16:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // monitor: counts strobe cycles/pulses and scores each response against the queue
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            n_wr  += int'(wr_en);
            n_rd  += int'(rd_en);
            n_to  += int'(reg_to);
            n_ovr += int'(overrun);
            if (tx_req && !prev_req) begin
                n_tx++;
                rise_cyc = cyc;
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL tx_unexpected: observed=%0h expected=none", {adc_sel, tx_cmd, tx_data});
                end
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("tx_frame", {15'd0, adc_sel, tx_cmd, tx_data}, {15'd0, cur});
                end
            end else if (tx_req) begin
                chk("tx_stable", {15'd0, adc_sel, tx_cmd, tx_data}, {15'd0, cur});
            end
            prev_req = tx_req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] d, input logic s);
        vld = 1'b1; rx_cmd = c; rx_data = d; rx_status = s;
        tick();
        vld = 1'b0; rx_cmd = '0; rx_data = '0; rx_status = 1'b0;
    endtask

    task automatic ack_now(input logic [7:0] rd, output int edge_cyc);
        ack = 1'b1; rdata = rd;
        tick();
        edge_cyc = cyc;
        ack = 1'b0; rdata = '0;
    endtask

    task automatic wait_tx(input int n0);
        int k = 0;
        while (n_tx == n0 && k < 100) begin
            tick();
            k++;
        end
        chk("tx_seen", 32'(n_tx - n0), 32'd1);
    endtask

    task automatic finish_tx();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("req_drop", {31'd0, tx_req}, 32'd0);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int w0, r0, t0, x0, o0, e0;
        // reset state
        #1;
        chk("rst_outs", {wr_en, rd_en, tx_req, adc_sel, busy, overrun, reg_to, addr, 1'b0, tx_cmd, tx_data},
            32'd0);
        chk("rst_wdata", {24'd0, wdata}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // write, ack after 3 cycles
        w0 = n_wr; x0 = n_tx;
        send(8'h85, 8'h3C, 1'b0);
        exp_q.push_back({1'b0, 8'h85, 8'h3C});
        chk("wr_en", {31'd0, wr_en}, 32'd1);
        chk("wr_addr", {25'd0, addr}, 32'h05);
        chk("wr_wdata", {24'd0, wdata}, 32'h3C);
        chk("wr_no_rd", {31'd0, rd_en}, 32'd0);
        tick(); tick();
        ack_now(8'hEE, e0);
        chk("wr_cycles", 32'(n_wr - w0), 32'd3);
        wait_tx(x0);
        chk("wr_latency", 32'(rise_cyc - e0), 32'(TURN_CYC));
        finish_tx();

        // normal read
        r0 = n_rd; x0 = n_tx;
        send(8'h12, 8'h00, 1'b0);
        exp_q.push_back({1'b0, 8'h12, 8'hA7});
        chk("rd_en", {31'd0, rd_en}, 32'd1);
        chk("rd_addr", {25'd0, addr}, 32'h12);
        chk("rd_no_wr", {31'd0, wr_en}, 32'd0);
        tick();
        ack_now(8'hA7, e0);
        chk("rd_cycles", 32'(n_rd - r0), 32'd2);
        wait_tx(x0);
        chk("rd_latency", 32'(rise_cyc - e0), 32'(TURN_CYC));
        finish_tx();

        // ADC burst read
        w0 = n_wr; r0 = n_rd; x0 = n_tx;
        send(8'h1F, 8'h55, 1'b0);
        e0 = cyc;
        exp_q.push_back({1'b1, 8'h1F, 8'h00});
        chk("adc_busy", {31'd0, busy}, 32'd1);
        wait_tx(x0);
        chk("adc_latency", 32'(rise_cyc - e0), 32'(TURN_CYC));
        chk("adc_no_strobe", 32'((n_wr - w0) + (n_rd - r0)), 32'd0);
        finish_tx();
        chk("adc_sel_clear", {31'd0, adc_sel}, 32'd0);

        // errored frame
        w0 = n_wr; r0 = n_rd; x0 = n_tx;
        send(8'h85, 8'h3C, 1'b1);
        chk("err_busy", {31'd0, busy}, 32'd0);
        repeat (5) tick();
        chk("err_no_strobe", 32'((n_wr - w0) + (n_rd - r0)), 32'd0);
        chk("err_no_tx", 32'(n_tx - x0), 32'd0);

        // ack timeout
        w0 = n_wr; t0 = n_to; x0 = n_tx;
        send(8'h90, 8'h11, 1'b0);
        repeat (ACK_TO_CYC + 4) tick();
        chk("to_wr_cycles", 32'(n_wr - w0), 32'(ACK_TO_CYC));
        chk("to_pulses", 32'(n_to - t0), 32'd1);
        chk("to_idle", {31'd0, busy}, 32'd0);
        chk("to_no_tx", 32'(n_tx - x0), 32'd0);

        // ack in the last allowed cycle completes normally
        w0 = n_wr; t0 = n_to; x0 = n_tx;
        send(8'h90, 8'h22, 1'b0);
        exp_q.push_back({1'b0, 8'h90, 8'h22});
        repeat (ACK_TO_CYC - 1) tick();
        ack_now(8'h00, e0);
        chk("late_ack_busy", {31'd0, busy}, 32'd1);
        chk("late_ack_wr_cycles", 32'(n_wr - w0), 32'(ACK_TO_CYC));
        wait_tx(x0);
        chk("late_ack_no_to", 32'(n_to - t0), 32'd0);
        finish_tx();

        // overrun during TURN, and vld coincident with done
        o0 = n_ovr; x0 = n_tx;
        send(8'h85, 8'h5A, 1'b0);
        exp_q.push_back({1'b0, 8'h85, 8'h5A});
        ack_now(8'h00, e0);
        tick(); tick();
        send(8'h12, 8'h99, 1'b0);
        chk("ovr_pulse", {31'd0, overrun}, 32'd1);
        tick();
        chk("ovr_one_cycle", {31'd0, overrun}, 32'd0);
        wait_tx(x0);
        chk("ovr_latency", 32'(rise_cyc - e0), 32'(TURN_CYC));
        vld = 1'b1; rx_cmd = 8'h85; rx_data = 8'h01;
        done = 1'b1;
        tick();
        vld = 1'b0; done = 1'b0; rx_cmd = '0; rx_data = '0;
        chk("ovr_done_pulse", {31'd0, overrun}, 32'd1);
        chk("ovr_done_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("ovr_done_ignored", {31'd0, busy}, 32'd0);
        chk("ovr_count", 32'(n_ovr - o0), 32'd2);

        // asynchronous reset in TX
        x0 = n_tx;
        send(8'h12, 8'h00, 1'b0);
        exp_q.push_back({1'b0, 8'h12, 8'h44});
        ack_now(8'h44, e0);
        wait_tx(x0);
        chk("pre_rst_req", {31'd0, tx_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", {wr_en, rd_en, tx_req, adc_sel, busy, overrun, reg_to, addr, 1'b0, tx_cmd, tx_data},
            32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle", {31'd0, busy}, 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
